// File: rtl/dequant_shift_pkg.sv
// Shared constants and FSM encoding for the streaming dequantizer and its
// saturating clip helper.
package dequant_shift_pkg;
  localparam int WIDTH_DATA_IN  = 16;
  localparam int WIDTH_DATA_ADD = 32;
  localparam int WIDTH_SHIFT    = 5;
  localparam int WIDTH_CNT      = 16;
  // Wide enough for a 16-bit value shifted by up to 31 without losing sign.
  localparam int WIDTH_WIDE     = 48;

  localparam logic [WIDTH_DATA_ADD-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [WIDTH_DATA_ADD-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/sat_clip.sv
// Combinational signed clip from a wide value down to the accumulator width,
// flagging when the value did not fit.
module sat_clip #(
  parameter int WIDTH_IN  = dequant_shift_pkg::WIDTH_WIDE,
  parameter int WIDTH_OUT = dequant_shift_pkg::WIDTH_DATA_ADD
) (
  input  logic [WIDTH_IN-1:0]  din,
  output logic [WIDTH_OUT-1:0] dout,
  output logic                 ovf
);
  import dequant_shift_pkg::*;

  // Value fits iff every bit from the output sign bit upward matches.
  logic [WIDTH_IN-WIDTH_OUT:0] hi_bits;
  assign hi_bits = din[WIDTH_IN-1:WIDTH_OUT-1];

  always_comb begin
    ovf  = !((&hi_bits) || !(|hi_bits));
    dout = din[WIDTH_OUT-1:0];
    if (ovf) dout = din[WIDTH_IN-1] ? WIDTH_OUT'(SAT_MIN) : WIDTH_OUT'(SAT_MAX);
  end
endmodule

// File: rtl/dequant_shift.sv
// Streaming dequantizer: sign-extend, left-shift by a per-frame amount and
// saturate to the accumulator width, one configured frame at a time.
module dequant_shift #(
  parameter int WIDTH_DATA_IN  = dequant_shift_pkg::WIDTH_DATA_IN,
  parameter int WIDTH_DATA_ADD = dequant_shift_pkg::WIDTH_DATA_ADD,
  parameter int WIDTH_SHIFT    = dequant_shift_pkg::WIDTH_SHIFT,
  parameter int WIDTH_CNT      = dequant_shift_pkg::WIDTH_CNT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [WIDTH_SHIFT-1:0]    cfg_shift,
  input  logic [WIDTH_CNT-1:0]      cfg_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH_DATA_IN-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH_DATA_ADD-1:0] out_data,
  output logic                      sat_flag,
  output logic                      busy,
  output logic                      done
);
  import dequant_shift_pkg::*;

  localparam int STAGES = 2;

  state_t                    state, state_nxt;
  logic [WIDTH_SHIFT-1:0]    shift_q;
  logic [WIDTH_CNT-1:0]      len_q, cnt;
  logic [STAGES:1]           vld_pipe;
  logic [WIDTH_WIDE-1:0]     in_shl, s1_data;
  logic [WIDTH_DATA_ADD-1:0] clip_data;
  logic                      clip_ovf;
  logic                      en, in_hs, cfg_hs, last_out;

  assign out_valid = vld_pipe[STAGES];
  assign en        = !out_valid || out_ready;
  assign cfg_ready = (state == IDLE);
  assign cfg_hs    = cfg_valid && cfg_ready;
  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN) && en && (cnt < len_q);
  assign in_hs     = in_valid && in_ready;
  // Final element leaves S2 with nothing left behind it in S1.
  assign last_out  = (state == DRAIN) && out_valid && out_ready && !vld_pipe[1];

  assign in_shl = {{(WIDTH_WIDE-WIDTH_DATA_IN){in_data[WIDTH_DATA_IN-1]}}, in_data} << shift_q;

  sat_clip #(.WIDTH_IN(WIDTH_WIDE), .WIDTH_OUT(WIDTH_DATA_ADD)) u_clip (
    .din  (s1_data),
    .dout (clip_data),
    .ovf  (clip_ovf)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_hs && (cfg_len != '0)) state_nxt = RUN;
      RUN:     if (in_hs && (cnt == len_q - WIDTH_CNT'(1))) state_nxt = DRAIN;
      DRAIN:   if (last_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q  <= '0;
      len_q    <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      done <= (cfg_hs && (cfg_len == '0)) || last_out;
      if (cfg_hs) begin
        shift_q  <= cfg_shift;
        len_q    <= cfg_len;
        cnt      <= '0;
        sat_flag <= 1'b0;
      end else begin
        if (in_hs) cnt <= cnt + WIDTH_CNT'(1);
        if (en && vld_pipe[1] && clip_ovf) sat_flag <= 1'b1;
      end
    end
  end

  // Both stages advance together; a stalled S2 freezes the whole pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      s1_data  <= '0;
      out_data <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_hs};
      if (in_hs)       s1_data  <= in_shl;
      if (vld_pipe[1]) out_data <= clip_data;
    end
  end
endmodule
